// File: rtl/fir_sample_mem_ctrl.sv
// FIR delay-line controller: clears the sample RAM, writes each accepted sample into a circular
// delay line, then streams the line newest-to-oldest as one tap frame per sample.
module fir_sample_mem_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int N_TAPS     = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_adres,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  tap_valid,
    output logic [DATA_WIDTH-1:0] tap_data,
    output logic [ADDR_WIDTH-1:0] tap_idx,
    output logic                  tap_last,
    output logic                  frame_done
);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_TAPS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] wptr, wptr_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nxt;
    logic [DATA_WIDTH-1:0] sample, sample_nxt;
    logic                  wr_nxt;
    logic [ADDR_WIDTH-1:0] adres_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  tv0, tv0_nxt;
    logic [ADDR_WIDTH-1:0] idx0, idx0_nxt;
    logic                  last0, last0_nxt;
    logic                  done_nxt;

    assign in_ready = (state == S_IDLE) && !rst;
    assign tap_data = mem_q;

    always_comb begin
        state_nxt   = state;
        wptr_nxt    = wptr;
        cnt_nxt     = cnt;
        rd_addr_nxt = rd_addr;
        sample_nxt  = sample;
        wr_nxt      = 1'b0;
        adres_nxt   = '0;
        data_nxt    = '0;
        tv0_nxt     = 1'b0;
        idx0_nxt    = '0;
        last0_nxt   = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            S_CLEAR: begin
                wr_nxt    = 1'b1;
                adres_nxt = cnt;
                cnt_nxt   = cnt + ONE;
                if (cnt == LAST_IDX) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    sample_nxt = in_data;
                    state_nxt  = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_nxt      = 1'b1;
                adres_nxt   = wptr;
                data_nxt    = sample;
                rd_addr_nxt = wptr;
                cnt_nxt     = '0;
                state_nxt   = S_READ;
            end
            S_READ: begin
                // Walk backwards from the newest sample; wrap is explicit so any depth works.
                adres_nxt   = rd_addr;
                tv0_nxt     = 1'b1;
                idx0_nxt    = cnt;
                last0_nxt   = (cnt == LAST_IDX);
                rd_addr_nxt = (rd_addr == '0) ? LAST_IDX : rd_addr - ONE;
                cnt_nxt     = cnt + ONE;
                if (cnt == LAST_IDX) begin
                    cnt_nxt   = '0;
                    state_nxt = (RD_LAT != 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE: begin
                done_nxt  = 1'b1;
                wptr_nxt  = (wptr == LAST_IDX) ? '0 : wptr + ONE;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_CLEAR;
            wptr       <= '0;
            cnt        <= '0;
            rd_addr    <= '0;
            sample     <= '0;
            mem_wr     <= 1'b0;
            mem_adres  <= '0;
            mem_data   <= '0;
            tv0        <= 1'b0;
            idx0       <= '0;
            last0      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            wptr       <= wptr_nxt;
            cnt        <= cnt_nxt;
            rd_addr    <= rd_addr_nxt;
            sample     <= sample_nxt;
            mem_wr     <= wr_nxt;
            mem_adres  <= adres_nxt;
            mem_data   <= data_nxt;
            tv0        <= tv0_nxt;
            idx0       <= idx0_nxt;
            last0      <= last0_nxt;
            frame_done <= done_nxt;
        end
    end

    // Tap sideband follows the address by the RAM read latency so it lines up with mem_q.
    if (RD_LAT == 0) begin : g_lat0
        assign tap_valid = tv0;
        assign tap_idx   = idx0;
        assign tap_last  = last0;
    end else begin : g_lat1
        logic                  tv1;
        logic [ADDR_WIDTH-1:0] idx1;
        logic                  last1;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tv1   <= 1'b0;
                idx1  <= '0;
                last1 <= 1'b0;
            end else begin
                tv1   <= tv0;
                idx1  <= idx0;
                last1 <= last0;
            end
        end
        assign tap_valid = tv1;
        assign tap_idx   = idx1;
        assign tap_last  = last1;
    end

endmodule

// File: tb/tb_fir_sample_mem_ctrl.sv
// Bench for fir_sample_mem_ctrl with N_TAPS=4 and a registered-read RAM model; expected writes
// and taps come from a reference delay line and are queued at acceptance, popped on DUT output.
module tb_fir_sample_mem_ctrl;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int NT = 4;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] idx;
        logic          last;
        logic [AW-1:0] adr;
    } tap_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          mem_wr;
    logic [AW-1:0] mem_adres;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;
    logic          tap_valid;
    logic [DW-1:0] tap_data;
    logic [AW-1:0] tap_idx;
    logic          tap_last;
    logic          frame_done;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    wr_t   exp_wr[$];
    tap_t  exp_tap[$];
    logic [DW-1:0] mdl_mem [0:NT-1];
    int    mdl_wptr;
    int    total = 0;
    int    bad = 0;
    int    frames = 0;
    int    handshakes = 0;
    logic  prev_last = 1'b0;
    logic [AW-1:0] prev_adres = '0;

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 16'hDEAD;
    end

    always @(posedge clk) begin
        if (mem_wr) ram[mem_adres] <= mem_data;
        mem_q <= ram[mem_adres];
    end

    fir_sample_mem_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_TAPS(NT), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_wr(mem_wr), .mem_adres(mem_adres), .mem_data(mem_data), .mem_q(mem_q),
        .tap_valid(tap_valid), .tap_data(tap_data), .tap_idx(tap_idx),
        .tap_last(tap_last), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < NT; a++) begin
            exp_wr.push_back('{adr: AW'(a), d: '0});
            mdl_mem[a] = '0;
        end
        mdl_wptr = 0;
    endtask

    task automatic model_accept(input logic [DW-1:0] d);
        handshakes++;
        mdl_mem[mdl_wptr] = d;
        exp_wr.push_back('{adr: AW'(mdl_wptr), d: d});
        for (int k = 0; k < NT; k++) begin
            int a;
            a = (mdl_wptr - k + NT) % NT;
            exp_tap.push_back('{d: mdl_mem[a], idx: AW'(k), last: (k == NT - 1), adr: AW'(a)});
        end
        mdl_wptr = (mdl_wptr + 1) % NT;
    endtask

    task automatic check_cycle();
        wr_t  w;
        tap_t t;
        if (!rst) begin
            if (mem_wr) begin
                chk("wr_expected", 32'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    chk("wr_adres", 32'(mem_adres), 32'(w.adr));
                    chk("wr_data", 32'(mem_data), 32'(w.d));
                end
            end
            if (tap_valid) begin
                chk("tap_expected", 32'(exp_tap.size() > 0), 1);
                if (exp_tap.size() > 0) begin
                    t = exp_tap.pop_front();
                    chk("tap_data", 32'(tap_data), 32'(t.d));
                    chk("tap_idx", 32'(tap_idx), 32'(t.idx));
                    chk("tap_last", 32'(tap_last), 32'(t.last));
                    chk("rd_adres", 32'(prev_adres), 32'(t.adr));
                end
            end
            chk("frame_done_align", 32'(frame_done), 32'(prev_last));
            if (frame_done) frames++;
            prev_last  = tap_valid & tap_last;
            prev_adres = mem_adres;
        end
    endtask

    // Acceptance is decided from inputs and in_ready as they stand just before the next edge.
    task automatic tick();
        if (in_valid && in_ready && !rst) model_accept(in_data);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic chk_outputs_zero();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_mem_adres", 32'(mem_adres), 0);
        chk("rst_mem_data", 32'(mem_data), 0);
        chk("rst_tap_valid", 32'(tap_valid), 0);
        chk("rst_tap_idx", 32'(tap_idx), 0);
        chk("rst_tap_last", 32'(tap_last), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_outputs_zero();
        exp_wr.delete();
        exp_tap.delete();
        prev_last = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < NT - 1; i++) begin
            tick();
            chk("clear_in_ready_low", 32'(in_ready), 0);
        end
        tick();
        chk("idle_in_ready_high", 32'(in_ready), 1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !in_ready; i++) tick();
        chk("ready_timeout", 32'(in_ready), 1);
    endtask

    task automatic send(input logic [DW-1:0] d);
        int gap;
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        gap = 1;
        while (!in_ready && gap < 100) begin
            tick();
            gap++;
        end
        chk("accept_to_ready_cycles", 32'(gap), NT + 4);
    endtask

    initial begin
        int frames_before;

        // CLEAR after reset, then the first frame over a cleared line
        do_reset();
        send(16'h00AA);
        chk("frames_after_first", 32'(frames), 1);

        // three samples: third written at 2, read 2,1,0,3
        do_reset();
        send(16'h00AA);
        send(16'h0055);
        send(16'h00CC);

        // five samples: write pointer wraps back to 0
        do_reset();
        for (int i = 1; i <= 5; i++) send(16'(i));
        chk("wptr_wrapped", 32'(mdl_wptr), 1);

        // in_valid held with changing data across busy frames
        wait_ready();
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_data = 16'h0100 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        wait_ready();
        chk("frames_vs_handshakes", 32'(frames), 32'(handshakes));

        // reset during READ of the second frame
        do_reset();
        send(16'h0011);
        in_valid = 1'b1;
        in_data  = 16'h0022;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        frames_before = frames;
        rst = 1'b1;
        #1;
        chk_outputs_zero();
        exp_wr.delete();
        exp_tap.delete();
        prev_last = 1'b0;
        tick();
        tick();
        chk("no_done_on_abort", 32'(frames), 32'(frames_before));
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < NT; i++) tick();
        chk("ready_after_reclear", 32'(in_ready), 1);
        send(16'h1234);
        chk("frames_after_abort", 32'(frames), 32'(frames_before + 1));

        for (int i = 0; i < 4; i++) tick();
        chk("wr_queue_drained", 32'(exp_wr.size()), 0);
        chk("tap_queue_drained", 32'(exp_tap.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_sample_mem_ctrl.md
Name: fir_sample_mem_ctrl

Overview:
Memory-side initiator for the FIR sample RAM. It owns the RAM's write and address ports and accepts input samples over a valid/ready handshake. Each sample is written into a circular delay line of N_TAPS entries. The block then reads the delay line back newest-to-oldest and streams it to the MAC datapath as one frame per sample.

Parameters:
ADDR_WIDTH, 5, RAM address width; must match the attached ram instance.
DATA_WIDTH, 16, sample width; must match the ram data width.
N_TAPS, 32, delay-line depth; 2 <= N_TAPS <= 2**ADDR_WIDTH; need not be a power of two.
RD_LAT, 1, RAM read latency in cycles (0 = combinational data_out, 1 = registered); only 0 and 1 are legal.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input sample valid
in_data  in  DATA_WIDTH  input sample
in_ready  out  1  block can accept a sample
mem_wr  out  1  RAM write enable (drives ram.wr)
mem_adres  out  ADDR_WIDTH  RAM address (drives ram.adres)
mem_data  out  DATA_WIDTH  RAM write data (drives ram.data)
mem_q  in  DATA_WIDTH  RAM read data (from ram.data_out)
tap_valid  out  1  tap_data/tap_idx are valid this cycle
tap_data  out  DATA_WIDTH  delay-line sample (x[n-tap_idx])
tap_idx  out  ADDR_WIDTH  tap index 0..N_TAPS-1
tap_last  out  1  high with tap_valid on tap_idx = N_TAPS-1
frame_done  out  1  one-cycle pulse after the last tap of a frame

Behaviour:
- Reset (async assert, sync release)
  - State = CLEAR; wptr = 0; clear counter = 0.
  - mem_wr, mem_adres, mem_data, tap_valid, tap_idx, tap_last and frame_done are all 0.
  - in_ready is 0 while rst is high.
- States: CLEAR, IDLE, WRITE, READ, DRAIN, DONE. All outputs except tap_data and in_ready are registered.
- CLEAR
  - One write per cycle: mem_wr=1, mem_data=0, mem_adres=0..N_TAPS-1.
  - Takes N_TAPS cycles, then moves to IDLE.
  - in_ready=0 throughout.
- IDLE
  - in_ready = 1 (combinational: state==IDLE and not rst).
  - When in_valid and in_ready at a clock edge: latch in_data and go to WRITE.
  - Otherwise stay in IDLE. All mem/tap outputs are 0.
- WRITE
  - Exactly one cycle: mem_wr=1, mem_adres=wptr, mem_data=latched sample. Then go to READ.
- READ
  - N_TAPS cycles, k=0..N_TAPS-1.
  - mem_wr=0, mem_adres=(wptr-k) mod N_TAPS, with wrap handled explicitly for non-power-of-two N_TAPS.
  - After the last address: go to DRAIN if RD_LAT=1, otherwise to DONE.
- Tap alignment
  - tap_valid, tap_idx=k and tap_last=(k==N_TAPS-1) are delayed RD_LAT cycles from the cycle address k was issued.
  - tap_data = mem_q (pass-through), valid only while tap_valid=1.
- DRAIN: one cycle, no address issued, last tap emerges. Then DONE.
- DONE
  - frame_done=1 for one cycle; wptr <= (wptr+1) mod N_TAPS.
  - Return to IDLE; in_ready is high the following cycle.
- Throughput: one sample per N_TAPS+RD_LAT+3 cycles (accept, WRITE, READ×N_TAPS, DRAIN×RD_LAT, DONE).
- Frame contents: tap 0 is always the just-written sample (write precedes its read by one edge). Taps never written since reset read as 0.
- in_valid outside IDLE: ignored, no effect, no buffering; the source must hold until in_ready.
- wptr wrap: N_TAPS-1 wraps to 0; read addresses wrap from 0 to N_TAPS-1.
- Reset mid-operation (any state): immediate return to reset values; the in-flight frame is abandoned with no frame_done; CLEAR reruns.
- mem_adres bits above the N_TAPS range are never driven to out-of-range values.

Test Plan:
(Bench: ADDR_WIDTH=5, DATA_WIDTH=16, N_TAPS=4, RD_LAT=1, ram model with registered read.)
1. Release rst -> mem_wr=1 for 4 cycles at addresses 0,1,2,3 with data 0; in_ready=0 during CLEAR, then 1 in IDLE; no tap_valid.
2. Send 0x00AA once in_ready=1 -> WRITE at addr 0 with data 0x00AA; taps idx0..3 = 0x00AA,0,0,0; tap_last on idx3; frame_done exactly one cycle later; next in_ready 8 cycles after acceptance.
3. Send 0x00AA, 0x0055, 0x00CC -> third frame taps = 0x00CC,0x0055,0x00AA,0x0000, written at addr 2, read addresses 2,1,0,3.
4. Send 1,2,3,4,5 -> fifth sample written at addr 0 (wptr wrap); fifth frame taps = 5,4,3,2, read addresses 0,3,2,1.
5. Hold in_valid=1 with changing in_data during a busy frame -> no extra writes; exactly one sample accepted per IDLE visit; frame count equals in_valid&&in_ready handshakes.
6. Assert rst during READ of the second frame -> all outputs 0 immediately, no frame_done; after release, CLEAR rewrites 0 to addresses 0..3 and the next frame shows new sample,0,0,0.
